spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
- Master-mode SPI transfer sequencer behind the APB register slave.
- Takes the configuration and transmit byte from the slave, then generates the SPI clock, slave-select, MOSI shifting and MISO capture.
- Returns the received byte plus a completion pulse.
- Drives tip_o back to the slave for status and interrupt generation.

Parameters:
- DATA_W, 8, shift register width (bits per frame).
- DIV_W, 12, baud half-period counter width; must hold 8*2^7.

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESET_n  input  1  asynchronous active-low reset.
- spe_i  input  1  SPI system enable; 0 aborts or blocks transfers.
- mstr_i  input  1  master mode; 0 makes the block ignore send requests.
- cpol_i  input  1  SCLK idle level.
- cpha_i  input  1  clock phase.
- lsbfe_i  input  1  1 = LSB first, 0 = MSB first.
- sppr_i  input  3  baud prescaler.
- spr_i  input  3  baud shift.
- send_data_i  input  1  one-cycle start request.
- mosi_data_i  input  DATA_W  transmit byte.
- miso_i  input  1  serial input from the slave device.
- sclk_o  output  1  SPI clock.
- mosi_o  output  1  serial output.
- ss_o  output  1  active-low slave select.
- tip_o  output  1  transfer in progress.
- receive_data_o  output  1  one-cycle pulse when miso_data_o is valid.
- miso_data_o  output  DATA_W  received byte.

Behaviour:
- Reset values:
  - ss_o=1, tip_o=0, receive_data_o=0, mosi_o=0, miso_data_o=0.
  - sclk_o=0, and it follows cpol_i once out of reset.
  - FSM in IDLE; counters cleared.
- Half-period H = (sppr_i+1) << spr_i PCLK cycles. H is 1..1024.
- Latching:
  - On accepted start: latch cpol, cpha, lsbfe, H and mosi_data_i.
  - Configuration changes during a frame have no effect until the next frame.
- Start acceptance: in IDLE, a start is accepted when send_data_i=1, spe_i=1 and mstr_i=1.
  - Otherwise send_data_i is ignored.
  - send_data_i while not in IDLE is ignored (no queueing).
- FSM states: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE.
- IDLE:
  - ss_o=1, tip_o=0, sclk_o=cpol_i.
  - Accepted start moves to LEAD the next cycle.
- LEAD:
  - ss_o=0, tip_o=1.
  - mosi_o = first bit: bit0 if lsbfe, else bit DATA_W-1.
  - Stays H cycles, then moves to XFER.
- XFER:
  - sclk_o toggles every H cycles, giving 2*DATA_W edges (edge counter 1..16).
  - Edges 1,3,... are leading edges; even edges are trailing edges.
  - CPHA=0: sample miso_i on leading edges; shift the next bit onto mosi_o on trailing edges except the last.
  - CPHA=1: shift on leading edges (first leading edge drives the first bit); sample on trailing edges.
  - Received bits fill from the MSB end if lsbfe=0, from the LSB end if lsbfe=1.
  - The sample on edge 16 (CPHA=1) or edge 15 (CPHA=0) completes the byte.
  - After edge 16, sclk_o equals the latched cpol; move to TRAIL.
- TRAIL:
  - ss_o stays 0 for H cycles, then the FSM moves to DONE.
- DONE (one cycle):
  - Load miso_data_o with the assembled byte.
  - Pulse receive_data_o=1.
  - ss_o=1, tip_o=0; return to IDLE.
- Latency: frame length from start-accept cycle to receive_data_o pulse = 1 + H*(2*DATA_W+2) cycles.
- Back-to-back: a start in the cycle after DONE is accepted; ss_o deasserts for at least 1 cycle between frames.
- Abort: spe_i=0 in any non-IDLE state forces IDLE on the next edge.
  - ss_o=1, tip_o=0, sclk_o=cpol_i.
  - No receive_data_o pulse; miso_data_o retains its previous value.
- mstr_i falling mid-frame behaves as an abort.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous).
- Counter arithmetic is unsigned; the half-period counter reloads to H-1 and counts down to 0. There is no wrap beyond its maximum.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- Defined:
  - Adds input port loop_i (1 bit).
  - When loop_i=1, the sampled bit is taken from internal mosi_o instead of miso_i, so a frame returns miso_data_o == transmitted byte.
  - ss_o and sclk_o still toggle.
- Undefined: port absent; sampling always uses miso_i.

Test Plan:
1. Reset, then sppr=0, spr=0 (H=1), cpol=0, cpha=0, lsbfe=0, send 8'hA5 with miso_i driven from a slave model returning 8'h3C:
   - mosi_o bit sequence is 1,0,1,0,0,1,0,1.
   - miso_data_o=8'h3C.
   - receive_data_o pulses exactly 19 cycles after the accept cycle.
2. Repeat 8'hA5 for all four {cpol,cpha} with lsbfe=1:
   - Sampling and shifting occur on the correct edges for each mode.
   - Idle sclk_o = cpol.
   - mosi_o sequence is 1,0,1,0,0,1,0,1 reversed.
3. sppr=7, spr=7:
   - H=1024; each sclk_o half-period is 1024 cycles.
   - Frame length is 18433 cycles.
4. Assert send_data_i during XFER with mosi_data_i changed to 8'hFF, and change cpol mid-frame:
   - Both are ignored.
   - The original frame completes unchanged with one receive pulse.
5. Drop spe_i at edge 5:
   - Next cycle ss_o=1, tip_o=0, sclk_o=cpol.
   - No receive pulse; miso_data_o unchanged.
   - A new start afterwards completes a normal frame.
6. Assert PRESET_n=0 mid-XFER: all outputs return to reset values without a clock. With SPI_LOOPBACK_EN and loop_i=1, send 8'h5A: miso_data_o=8'h5A.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// Master-mode SPI frame sequencer: IDLE -> LEAD -> XFER -> TRAIL -> DONE.
// Define SPI_LOOPBACK_EN to add loop_i, which samples the internal MOSI instead of miso_i.
module spi_xfer_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 12
) (
   input  logic              PCLK,
   input  logic              PRESET_n,
   input  logic              spe_i,
   input  logic              mstr_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic              lsbfe_i,
   input  logic [2:0]        sppr_i,
   input  logic [2:0]        spr_i,
   input  logic              send_data_i,
   input  logic [DATA_W-1:0] mosi_data_i,
`ifdef SPI_LOOPBACK_EN
   input  logic              loop_i,
`endif
   input  logic              miso_i,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              ss_o,
   output logic              tip_o,
   output logic              receive_data_o,
   output logic [DATA_W-1:0] miso_data_o
);

   localparam int unsigned      EdgeW    = $clog2(2 * DATA_W + 1);
   localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W);
   localparam logic [EdgeW-1:0] OneEdge  = EdgeW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StLead,
      StXfer,
      StTrail,
      StDone
   } state_e;

   state_e            state_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  half_m1_q;
   logic [EdgeW-1:0]  edge_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] miso_data_q;
   logic              cpol_q;
   logic              cpha_q;
   logic              lsbfe_q;
   logic              sclk_q;
   logic              mosi_q;
   logic              ss_q;
   logic              tip_q;
   logic              rx_valid_q;

   logic [DIV_W-1:0]  half_m1;
   logic [EdgeW-1:0]  edge_n;
   logic              start;
   logic              abort;
   logic              div_done;
   logic              lead_edge;
   logic              do_sample;
   logic              do_shift;
   logic              first_bit;
   logic              next_bit;
   logic              sample_bit;
   logic [DATA_W-1:0] tx_shifted;
   logic [DATA_W-1:0] rx_shifted;

   // Half-period minus one, so the divider reloads and counts down to zero.
   assign half_m1 = ((DIV_W'(sppr_i) + DIV_W'(1)) << spr_i) - DIV_W'(1);

   assign start    = (state_q == StIdle) && send_data_i && spe_i && mstr_i;
   assign abort    = (state_q != StIdle) && !(spe_i && mstr_i);
   assign div_done = (div_q == '0);

   assign edge_n    = edge_q + OneEdge;
   assign lead_edge = edge_n[0];

   // CPHA=1 shifts on leading edges, but the first bit is already on MOSI from LEAD.
   assign do_sample = cpha_q ? !lead_edge : lead_edge;
   assign do_shift  = cpha_q ? (lead_edge && (edge_n != OneEdge))
                             : (!lead_edge && (edge_n != LastEdge));

   assign first_bit  = lsbfe_i ? mosi_data_i[0] : mosi_data_i[DATA_W-1];
   assign next_bit   = lsbfe_q ? tx_q[1] : tx_q[DATA_W-2];
   assign tx_shifted = lsbfe_q ? (tx_q >> 1) : (tx_q << 1);

`ifdef SPI_LOOPBACK_EN
   assign sample_bit = loop_i ? mosi_q : miso_i;
`else
   assign sample_bit = miso_i;
`endif

   assign rx_shifted = lsbfe_q ? {sample_bit, rx_q[DATA_W-1:1]}
                               : {rx_q[DATA_W-2:0], sample_bit};

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         state_q     <= StIdle;
         div_q       <= '0;
         half_m1_q   <= '0;
         edge_q      <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         miso_data_q <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         lsbfe_q     <= 1'b0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         ss_q        <= 1'b1;
         tip_q       <= 1'b0;
         rx_valid_q  <= 1'b0;
      end else if (abort) begin
         state_q    <= StIdle;
         ss_q       <= 1'b1;
         tip_q      <= 1'b0;
         sclk_q     <= cpol_i;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               ss_q   <= 1'b1;
               tip_q  <= 1'b0;
               sclk_q <= cpol_i;
               if (start) begin
                  state_q   <= StLead;
                  ss_q      <= 1'b0;
                  tip_q     <= 1'b1;
                  cpol_q    <= cpol_i;
                  cpha_q    <= cpha_i;
                  lsbfe_q   <= lsbfe_i;
                  half_m1_q <= half_m1;
                  div_q     <= half_m1;
                  edge_q    <= '0;
                  tx_q      <= mosi_data_i;
                  mosi_q    <= first_bit;
                  rx_q      <= '0;
               end
            end
            StLead: begin
               if (div_done) begin
                  state_q <= StXfer;
                  div_q   <= half_m1_q;
               end else begin
                  div_q <= div_q - DIV_W'(1);
               end
            end
            StXfer: begin
               if (div_done) begin
                  div_q  <= half_m1_q;
                  edge_q <= edge_n;
                  sclk_q <= ~sclk_q;
                  if (do_sample) begin
                     rx_q <= rx_shifted;
                  end
                  if (do_shift) begin
                     tx_q   <= tx_shifted;
                     mosi_q <= next_bit;
                  end
                  if (edge_n == LastEdge) begin
                     state_q <= StTrail;
                  end
               end else begin
                  div_q <= div_q - DIV_W'(1);
               end
            end
            StTrail: begin
               if (div_done) begin
                  state_q     <= StDone;
                  ss_q        <= 1'b1;
                  tip_q       <= 1'b0;
                  rx_valid_q  <= 1'b1;
                  miso_data_q <= rx_q;
               end else begin
                  div_q <= div_q - DIV_W'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               sclk_q  <= cpol_i;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign sclk_o         = sclk_q;
   assign mosi_o         = mosi_q;
   assign ss_o           = ss_q;
   assign tip_o          = tip_q;
   assign receive_data_o = rx_valid_q;
   assign miso_data_o    = miso_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomised bench for spi_xfer_ctrl: a frame-timeline model predicts every output each cycle.
module tb_spi_xfer_ctrl;

   logic       PCLK = 1'b0;
   logic       PRESET_n = 1'b0;
   logic       spe_i = 1'b1;
   logic       mstr_i = 1'b1;
   logic       cpol_i = 1'b0;
   logic       cpha_i = 1'b0;
   logic       lsbfe_i = 1'b0;
   logic [2:0] sppr_i = 3'd0;
   logic [2:0] spr_i = 3'd0;
   logic       send_data_i = 1'b0;
   logic [7:0] mosi_data_i = 8'h00;
   logic       miso_i = 1'b0;
`ifdef SPI_LOOPBACK_EN
   logic       loop_i = 1'b0;
`endif
   logic       sclk_o;
   logic       mosi_o;
   logic       ss_o;
   logic       tip_o;
   logic       receive_data_o;
   logic [7:0] miso_data_o;

   spi_xfer_ctrl #(
      .DATA_W(8),
      .DIV_W (12)
   ) u_dut (
      .PCLK          (PCLK),
      .PRESET_n      (PRESET_n),
      .spe_i         (spe_i),
      .mstr_i        (mstr_i),
      .cpol_i        (cpol_i),
      .cpha_i        (cpha_i),
      .lsbfe_i       (lsbfe_i),
      .sppr_i        (sppr_i),
      .spr_i         (spr_i),
      .send_data_i   (send_data_i),
      .mosi_data_i   (mosi_data_i),
`ifdef SPI_LOOPBACK_EN
      .loop_i        (loop_i),
`endif
      .miso_i        (miso_i),
      .sclk_o        (sclk_o),
      .mosi_o        (mosi_o),
      .ss_o          (ss_o),
      .tip_o         (tip_o),
      .receive_data_o(receive_data_o),
      .miso_data_o   (miso_data_o)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model: a frame is a timeline of t edges after accept; SCLK edge j sits at t = (j+1)*H.
   bit         m_busy = 0;
   int         m_t = 0;
   int         m_h = 1;
   bit         m_cpol, m_cpha, m_lsb;
   logic [7:0] m_tx = 8'h00;
   logic [7:0] m_rx = 8'h00;
   logic       e_ss = 1'b1, e_tip = 1'b0, e_sclk = 1'b0, e_mosi = 1'b0, e_rx = 1'b0;
   logic [7:0] e_data = 8'h00;

   function automatic int edge_j(input int t);
      if (t >= 2 * m_h && t <= 17 * m_h && (t % m_h) == 0) return t / m_h - 1;
      return 0;
   endfunction

   function automatic bit is_sample(input int j);
      return m_cpha ? (j % 2 == 0) : (j % 2 == 1);
   endfunction

   function automatic bit is_shift(input int j);
      return m_cpha ? (j % 2 == 1 && j > 1) : (j % 2 == 0 && j < 16);
   endfunction

   function automatic logic tx_bit(input int k);
      return m_lsb ? m_tx[k] : m_tx[7-k];
   endfunction

   task automatic model_step();
      int   j, s;
      logic sb;
      if (!PRESET_n) begin
         m_busy = 0; e_ss = 1; e_tip = 0; e_sclk = 0; e_mosi = 0; e_rx = 0; e_data = 8'h00;
      end else begin
         e_rx = 0;
         if (!m_busy) begin
            e_sclk = cpol_i;
            if (send_data_i && spe_i && mstr_i) begin
               m_busy = 1; m_t = 0;
               m_h = (int'(sppr_i) + 1) << spr_i;
               m_cpol = cpol_i; m_cpha = cpha_i; m_lsb = lsbfe_i;
               m_tx = mosi_data_i; m_rx = 8'h00;
               e_ss = 0; e_tip = 1; e_mosi = tx_bit(0);
            end else begin
               e_ss = 1; e_tip = 0;
            end
         end else if (!(spe_i && mstr_i) || m_t == 18 * m_h) begin
            m_busy = 0; e_ss = 1; e_tip = 0; e_sclk = cpol_i;
         end else begin
            m_t++;
            if (m_t == 18 * m_h) begin
               e_rx = 1; e_data = m_rx; e_ss = 1; e_tip = 0;
            end else begin
               j = edge_j(m_t);
               if (j > 0) begin
`ifdef SPI_LOOPBACK_EN
                  sb = loop_i ? e_mosi : miso_i;
`else
                  sb = miso_i;
`endif
                  if (is_sample(j)) begin
                     s = (j - 1) / 2;
                     if (m_lsb) m_rx[s] = sb;
                     else m_rx[7-s] = sb;
                  end
                  if (is_shift(j)) e_mosi = tx_bit(m_cpha ? (j - 1) / 2 : j / 2);
                  e_sclk = ~e_sclk;
               end
            end
         end
      end
   endtask

   initial begin : model_proc
      forever begin
         @(posedge PCLK or negedge PRESET_n);
         model_step();
      end
   end

   // Slave: presents the reply bit only on the cycle ending in a sample edge, noise elsewhere.
   logic [7:0] slave_reply = 8'h00;
   logic [7:0] mosi_seq = 8'h00;

   initial begin : slave_proc
      int j;
      forever begin
         @(negedge PCLK);
         miso_i = 1'($urandom_range(0, 1));
         if (m_busy && (m_t + 1) < 18 * m_h) begin
            j = edge_j(m_t + 1);
            if (j > 0 && is_sample(j)) begin
               miso_i = m_lsb ? slave_reply[(j-1)/2] : slave_reply[7-(j-1)/2];
               mosi_seq[7-(j-1)/2] = mosi_o;
            end
         end
      end
   end

   int   n_pulse = 0;
   int   last_tgl = 0;
   int   gap = 0;
   logic prev_sclk = 1'b0;

   initial begin : compare_proc
      forever begin
         @(negedge PCLK);
         check("ss_o", 32'(ss_o), 32'(e_ss));
         check("tip_o", 32'(tip_o), 32'(e_tip));
         check("sclk_o", 32'(sclk_o), 32'(e_sclk));
         check("receive_data_o", 32'(receive_data_o), 32'(e_rx));
         check("miso_data_o", 32'(miso_data_o), 32'(e_data));
         if (e_tip) check("mosi_o", 32'(mosi_o), 32'(e_mosi));
         if (receive_data_o === 1'b1) n_pulse++;
         if (sclk_o !== prev_sclk) begin
            gap = cyc - last_tgl;
            last_tgl = cyc;
            prev_sclk = sclk_o;
         end
      end
   end

   task automatic cfg(input bit cpol, input bit cpha, input bit lsb, input int sppr, input int spr);
      cpol_i = cpol; cpha_i = cpha; lsbfe_i = lsb;
      sppr_i = 3'(sppr); spr_i = 3'(spr);
   endtask

   task automatic start_frame(input logic [7:0] d, output int acc);
      @(negedge PCLK);
      mosi_data_i = d; send_data_i = 1'b1; mosi_seq = 8'h00; acc = cyc;
      @(negedge PCLK);
      send_data_i = 1'b0;
   endtask

   task automatic wait_rx(input int budget, output int rxc);
      rxc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge PCLK);
         if (receive_data_o === 1'b1) begin
            rxc = cyc;
            break;
         end
      end
      check("rx_within_budget", 32'(rxc >= 0), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ss"}, 32'(ss_o), 1);
      check({tag, "_tip"}, 32'(tip_o), 0);
      check({tag, "_rx"}, 32'(receive_data_o), 0);
      check({tag, "_mosi"}, 32'(mosi_o), 0);
      check({tag, "_sclk"}, 32'(sclk_o), 0);
      check({tag, "_data"}, 32'(miso_data_o), 0);
   endtask

   initial begin : stim_proc
      int         acc, rxc, p0, h, mid, ab_at;
      bit         ab;
      logic [7:0] r, r4;

      repeat (3) @(negedge PCLK);
      check_reset_vals("reset");
      PRESET_n = 1'b1;
      repeat (2) @(negedge PCLK);

      // H=1, mode 0, MSB first
      slave_reply = 8'h3C;
      start_frame(8'hA5, acc);
      wait_rx(40, rxc);
      check("t1_latency", rxc - acc, 19);
      check("t1_miso_data", 32'(miso_data_o), 32'h3C);
      check("t1_mosi_seq", 32'(mosi_seq), 32'hA5);

      // all four clock modes, LSB first
      for (int m = 0; m < 4; m++) begin
         cfg(m[1], m[0], 1'b1, 0, 0);
         repeat (2) @(negedge PCLK);
         check("t2_idle_sclk", 32'(sclk_o), 32'(m[1]));
         r = 8'($urandom);
         slave_reply = r;
         start_frame(8'hA5, acc);
         wait_rx(40, rxc);
         check("t2_latency", rxc - acc, 19);
         check("t2_miso_data", 32'(miso_data_o), 32'(r));
         check("t2_mosi_seq", 32'(mosi_seq), 32'hA5);
         repeat (2) @(negedge PCLK);
      end

      // slowest baud
      cfg(1'b1, 1'b1, 1'b0, 7, 7);
      repeat (2) @(negedge PCLK);
      r = 8'($urandom);
      slave_reply = r;
      start_frame(8'h96, acc);
      wait_rx(19000, rxc);
      check("t3_latency", rxc - acc, 18433);
      check("t3_half_period", gap, 1024);
      check("t3_miso_data", 32'(miso_data_o), 32'(r));
      check("t3_mosi_seq", 32'(mosi_seq), 32'h96);

      // mid-frame send and config change are ignored
      cfg(1'b0, 1'b1, 1'b0, 1, 0);
      repeat (2) @(negedge PCLK);
      r4 = 8'($urandom);
      slave_reply = r4;
      p0 = n_pulse;
      start_frame(8'h3A, acc);
      repeat (8) @(negedge PCLK);
      send_data_i = 1'b1; mosi_data_i = 8'hFF; cpol_i = 1'b1;
      @(negedge PCLK);
      send_data_i = 1'b0;
      wait_rx(60, rxc);
      check("t4_latency", rxc - acc, 37);
      check("t4_miso_data", 32'(miso_data_o), 32'(r4));
      check("t4_mosi_seq", 32'(mosi_seq), 32'h3A);
      repeat (5) @(negedge PCLK);
      check("t4_pulse_count", n_pulse - p0, 1);

      // abort at SCLK edge 5
      cfg(1'b1, 1'b0, 1'b0, 0, 0);
      repeat (2) @(negedge PCLK);
      r = 8'($urandom);
      slave_reply = r;
      p0 = n_pulse;
      start_frame(8'hC3, acc);
      repeat (5) @(negedge PCLK);
      spe_i = 1'b0;
      @(negedge PCLK);
      check("t5_ss", 32'(ss_o), 1);
      check("t5_tip", 32'(tip_o), 0);
      check("t5_sclk", 32'(sclk_o), 1);
      check("t5_data_kept", 32'(miso_data_o), 32'(r4));
      spe_i = 1'b1;
      repeat (25) @(negedge PCLK);
      check("t5_no_pulse", n_pulse - p0, 0);
      start_frame(8'h5E, acc);
      wait_rx(40, rxc);
      check("t5_restart_latency", rxc - acc, 19);
      check("t5_restart_data", 32'(miso_data_o), 32'(r));

      // asynchronous reset mid-XFER
      cfg(1'b0, 1'b0, 1'b0, 3, 0);
      repeat (2) @(negedge PCLK);
      start_frame(8'h77, acc);
      repeat (20) @(negedge PCLK);
      #2 PRESET_n = 1'b0;
      #1 check_reset_vals("t6_async_reset");
      repeat (2) @(negedge PCLK);
      PRESET_n = 1'b1;
      repeat (2) @(negedge PCLK);

`ifdef SPI_LOOPBACK_EN
      loop_i = 1'b1;
      cfg(1'b0, 1'b0, 1'b0, 0, 0);
      slave_reply = 8'h00;
      start_frame(8'h5A, acc);
      wait_rx(40, rxc);
      check("t6_loopback_data", 32'(miso_data_o), 32'h5A);
      loop_i = 1'b0;
      repeat (2) @(negedge PCLK);
`endif

      // randomised frames with occasional aborts and mid-frame interference
      for (int f = 0; f < 40; f++) begin
         cfg(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
         h = (int'(sppr_i) + 1) << spr_i;
         slave_reply = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge PCLK);
         start_frame(8'($urandom), acc);
         ab = ($urandom_range(0, 4) == 0);
         ab_at = $urandom_range(1, 18 * h);
         mid = $urandom_range(0, 18 * h - 2);
         for (int c = 0; c < 18 * h + 2; c++) begin
            @(negedge PCLK);
            spe_i = 1'b1; mstr_i = 1'b1; send_data_i = 1'b0;
            if (ab && c == ab_at) begin
               if ($urandom_range(0, 1) == 0) spe_i = 1'b0;
               else mstr_i = 1'b0;
            end else if (!ab && c == mid) begin
               cfg(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                   $urandom_range(0, 7));
               mosi_data_i = 8'($urandom);
               send_data_i = 1'b1;
            end
         end
         spe_i = 1'b1; mstr_i = 1'b1; send_data_i = 1'b0;
      end

      repeat (5) @(negedge PCLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
